// File: rtl/r2sdf_stage1_if.sv
// Sample-stream bundle for the first radix-2 single-path delay-feedback stage.
// The master drives complex input samples; the slave returns registered sums/differences.
interface r2sdf_stage1_if #(
    parameter int WIDTH = 10
);
    logic                    data_in_en;
    logic signed [WIDTH-1:0] data_in_re;
    logic signed [WIDTH-1:0] data_in_im;
    logic                    data_out_en;
    logic                    data_out_sof;
    logic signed [WIDTH:0]   data_out_re;
    logic signed [WIDTH:0]   data_out_im;

    modport master (
        output data_in_en,
        output data_in_re,
        output data_in_im,
        input  data_out_en,
        input  data_out_sof,
        input  data_out_re,
        input  data_out_im
    );

    modport slave (
        input  data_in_en,
        input  data_in_re,
        input  data_in_im,
        output data_out_en,
        output data_out_sof,
        output data_out_re,
        output data_out_im
    );
endinterface

// File: rtl/r2sdf_stage1.sv
// First stage of a radix-2 SDF FFT pipeline.
// The first half of each frame fills a DEPTH-deep feedback delay line. The second half
// emits X[n]+X[n+DEPTH] and stores X[n]-X[n+DEPTH] back into the line. Those differences
// drain out while the next frame's first half is being loaded.
module r2sdf_stage1 #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    r2sdf_stage1_if.slave      bus
);
    localparam int CW = $clog2(2 * DEPTH);
    localparam int OW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

    typedef logic signed [OW-1:0] samp_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          diff_valid_q, diff_valid_d;
    samp_t         dl_re_q [DEPTH];
    samp_t         dl_re_d [DEPTH];
    samp_t         dl_im_q [DEPTH];
    samp_t         dl_im_d [DEPTH];
    logic          out_en_q, out_en_d;
    logic          out_sof_q, out_sof_d;
    samp_t         out_re_q, out_re_d;
    samp_t         out_im_q, out_im_d;

    samp_t in_re_ext, in_im_ext;
    samp_t head_re, head_im;
    samp_t push_re, push_im;

    // Next-state logic: only an accepted sample moves the counter, the line or the outputs.
    always_comb begin
        cnt_d        = cnt_q;
        diff_valid_d = diff_valid_q;
        dl_re_d      = dl_re_q;
        dl_im_d      = dl_im_q;
        out_en_d     = 1'b0;
        out_sof_d    = 1'b0;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;
        in_re_ext    = {bus.data_in_re[WIDTH-1], bus.data_in_re};
        in_im_ext    = {bus.data_in_im[WIDTH-1], bus.data_in_im};
        head_re      = dl_re_q[DEPTH-1];
        head_im      = dl_im_q[DEPTH-1];
        push_re      = in_re_ext;
        push_im      = in_im_ext;

        if (bus.data_in_en) begin
            if (cnt_q >= CNT_HALF) begin
                out_re_d = head_re + in_re_ext;
                out_im_d = head_im + in_im_ext;
                push_re  = head_re - in_re_ext;
                push_im  = head_im - in_im_ext;
                out_en_d = 1'b1;
            end else begin
                out_re_d = head_re;
                out_im_d = head_im;
                out_en_d = diff_valid_q;
            end
            out_sof_d = (cnt_q == CNT_HALF);

            for (int i = DEPTH - 1; i > 0; i--) begin
                dl_re_d[i] = dl_re_q[i-1];
                dl_im_d[i] = dl_im_q[i-1];
            end
            dl_re_d[0] = push_re;
            dl_im_d[0] = push_im;

            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                diff_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and output registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            diff_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
            out_en_q     <= 1'b0;
            out_sof_q    <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            diff_valid_q <= diff_valid_d;
            dl_re_q      <= dl_re_d;
            dl_im_q      <= dl_im_d;
            out_en_q     <= out_en_d;
            out_sof_q    <= out_sof_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
        end
    end

    assign bus.data_out_en  = out_en_q;
    assign bus.data_out_sof = out_sof_q;
    assign bus.data_out_re  = out_re_q;
    assign bus.data_out_im  = out_im_q;
endmodule
